// File: rtl/pc_redirect_ctrl.sv
// Pipeline sequencing controller for the 5-stage RISC-V core.
// Drives the PC-mux select and every pipeline write-enable/flush. It resolves EX redirects,
// ID load-use hazards, multi-cycle fetch and data-memory stalls. A redirect that arrives
// while the fetch port is busy is latched and applied once the in-flight fetch completes.
// Optional feature macro: PC_REDIRECT_PERF_EN enables the wrapping performance counters;
// when it is undefined the counter outputs are tied to zero and no counter flops exist.
module pc_redirect_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             jal_ex,
    input  logic             jalr_ex,
    input  logic             br_ex,
    input  logic [XLEN-1:0]  jalr_tgt_ex,
    input  logic [XLEN-1:0]  alu_tgt_ex,
    input  logic             memrd_ex,
    input  logic [4:0]       rd_ex,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_use_id,
    input  logic             rs2_use_id,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [1:0]       pc_sel,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_hold,
    output logic             redir_pending,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] loaduse_cnt,
    output logic [CNT_W-1:0] dstall_cnt
);

    typedef enum logic {StRun, StWait} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              redir;
    logic              lu;
    logic [1:0]        tgt_sel;
    logic [XLEN-1:0]   tgt;

    // Hazard detection and redirect target selection (jal > jalr > br).
    always_comb begin
        redir = ex_valid & (jal_ex | jalr_ex | br_ex);
        if (jal_ex) begin
            tgt_sel = 2'd2;
            tgt     = alu_tgt_ex;
        end else if (jalr_ex) begin
            tgt_sel = 2'd1;
            tgt     = jalr_tgt_ex;
        end else begin
            tgt_sel = 2'd2;
            tgt     = alu_tgt_ex;
        end
        lu = ex_valid & memrd_ex & (rd_ex != 5'd0) &
             ((rs1_use_id & (rs1_id == rd_ex)) | (rs2_use_id & (rs2_id == rd_ex)));
    end

    // Prioritised per-cycle control decode and next-state logic.
    always_comb begin
        pc_sel        = 2'd0;
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        id_ex_we      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        pipe_hold     = 1'b0;
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;

        if (!dmem_ready) begin
            // Whole pipe frozen; an EX redirect stays put and is re-presented later.
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            pipe_hold = 1'b1;
        end else if (state_q == StWait) begin
            // The fetch in flight is stale: discard it whatever it returns.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (imem_ready) begin
                pc_sel  = 2'd3;
                state_d = StRun;
            end else begin
                pc_we = 1'b0;
            end
        end else if (redir) begin
            // Redirect wins over load-use: the ID instruction is flushed anyway.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (imem_ready) begin
                pc_sel = tgt_sel;
            end else begin
                pc_we         = 1'b0;
                redirect_pc_d = tgt;
                state_d       = StWait;
            end
        end else if (lu) begin
            // One bubble; the load leaves EX next cycle.
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    // State and latched redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StRun;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign redirect_pc   = redirect_pc_q;
    assign redir_pending = (state_q == StWait);

`ifdef PC_REDIRECT_PERF_EN
    logic [CNT_W-1:0] redirect_cnt_q, loaduse_cnt_q, dstall_cnt_q;
    logic             ev_redirect, ev_loaduse, ev_dstall;

    // Counter events mirror the decode priority above.
    always_comb begin
        ev_dstall   = ~dmem_ready;
        ev_redirect = dmem_ready & (state_q == StRun) & redir;
        ev_loaduse  = dmem_ready & (state_q == StRun) & ~redir & lu;
    end

    // Wrapping performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_q <= '0;
            loaduse_cnt_q  <= '0;
            dstall_cnt_q   <= '0;
        end else begin
            if (ev_redirect) redirect_cnt_q <= redirect_cnt_q + 1'b1;
            if (ev_loaduse)  loaduse_cnt_q  <= loaduse_cnt_q + 1'b1;
            if (ev_dstall)   dstall_cnt_q   <= dstall_cnt_q + 1'b1;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign loaduse_cnt  = loaduse_cnt_q;
    assign dstall_cnt   = dstall_cnt_q;
`else
    assign redirect_cnt = '0;
    assign loaduse_cnt  = '0;
    assign dstall_cnt   = '0;
`endif

`ifndef SYNTHESIS
    // EX only sees bubbles while a redirect is pending.
    redir_in_wait_a: assert property (@(posedge clk) disable iff (rst)
        !((state_q == StWait) && redir));
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pc_redirect_ctrl;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             ex_valid, jal_ex, jalr_ex, br_ex, memrd_ex;
    logic [XLEN-1:0]  jalr_tgt_ex, alu_tgt_ex;
    logic [4:0]       rd_ex, rs1_id, rs2_id;
    logic             rs1_use_id, rs2_use_id, imem_ready, dmem_ready;
    logic [1:0]       pc_sel;
    logic [XLEN-1:0]  redirect_pc;
    logic             pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, pipe_hold;
    logic             redir_pending;
    logic [CNT_W-1:0] redirect_cnt, loaduse_cnt, dstall_cnt;

    int errors = 0;
    int checks = 0;

    pc_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .jal_ex       (jal_ex),
        .jalr_ex      (jalr_ex),
        .br_ex        (br_ex),
        .jalr_tgt_ex  (jalr_tgt_ex),
        .alu_tgt_ex   (alu_tgt_ex),
        .memrd_ex     (memrd_ex),
        .rd_ex        (rd_ex),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .rs1_use_id   (rs1_use_id),
        .rs2_use_id   (rs2_use_id),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .pc_sel       (pc_sel),
        .redirect_pc  (redirect_pc),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .id_ex_we     (id_ex_we),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .pipe_hold    (pipe_hold),
        .redir_pending(redir_pending),
        .redirect_cnt (redirect_cnt),
        .loaduse_cnt  (loaduse_cnt),
        .dstall_cnt   (dstall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic             m_pend;
    logic [XLEN-1:0]  m_rpc;
    logic [CNT_W-1:0] m_rc, m_lc, m_dc;

    function automatic logic m_redir();
        return ex_valid && (jal_ex || jalr_ex || br_ex);
    endfunction

    function automatic logic m_lu();
        if (!(ex_valid && memrd_ex) || rd_ex == 5'd0) return 1'b0;
        return (rs1_use_id && rs1_id == rd_ex) || (rs2_use_id && rs2_id == rd_ex);
    endfunction

    // Returns {pc_sel, pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, pipe_hold}.
    function automatic logic [7:0] m_ctrl();
        logic [1:0] sel;
        if (!dmem_ready)      return {2'd0, 6'b000001};
        if (m_pend)           return imem_ready ? {2'd3, 6'b111110} : {2'd0, 6'b011110};
        if (m_redir()) begin
            sel = jal_ex ? 2'd2 : (jalr_ex ? 2'd1 : 2'd2);
            return imem_ready ? {sel, 6'b111110} : {2'd0, 6'b011110};
        end
        if (m_lu())           return {2'd0, 6'b001010};
        if (!imem_ready)      return {2'd0, 6'b011100};
        return {2'd0, 6'b111000};
    endfunction

    function automatic logic [CNT_W-1:0] perf(input logic [CNT_W-1:0] v);
`ifdef PC_REDIRECT_PERF_EN
        return v;
`else
        return v & '0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend <= 1'b0;
            m_rpc  <= '0;
            m_rc   <= '0;
            m_lc   <= '0;
            m_dc   <= '0;
        end else if (!dmem_ready) begin
            m_dc <= m_dc + 1;
        end else if (m_pend) begin
            if (imem_ready) m_pend <= 1'b0;
        end else if (m_redir()) begin
            m_rc <= m_rc + 1;
            if (!imem_ready) begin
                m_pend <= 1'b1;
                m_rpc  <= jal_ex ? alu_tgt_ex : (jalr_ex ? jalr_tgt_ex : alu_tgt_ex);
            end
        end else if (m_lu()) begin
            m_lc <= m_lc + 1;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [7:0] e;
        e = m_ctrl();
        chk("ctrl", {56'd0, pc_sel, pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, pipe_hold},
            {56'd0, e});
        chk("redir_pending", 64'(redir_pending), 64'(m_pend));
        chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
        chk("redirect_cnt", 64'(redirect_cnt), 64'(perf(m_rc)));
        chk("loaduse_cnt", 64'(loaduse_cnt), 64'(perf(m_lc)));
        chk("dstall_cnt", 64'(dstall_cnt), 64'(perf(m_dc)));
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        ex_valid = 0; jal_ex = 0; jalr_ex = 0; br_ex = 0; memrd_ex = 0;
        jalr_tgt_ex = '0; alu_tgt_ex = '0; rd_ex = '0; rs1_id = '0; rs2_id = '0;
        rs1_use_id = 0; rs2_use_id = 0; imem_ready = 1; dmem_ready = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [CNT_W-1:0] rc0, dc0;
        rst = 1'b1;
        idle_inputs();
        #12;
        #1;
        chk("rst_pending", 64'(redir_pending), 64'd0);
        chk("rst_rpc", 64'(redirect_pc), 64'd0);
        chk("rst_pc_sel", 64'(pc_sel), 64'd0);
        chk("rst_pc_we", 64'(pc_we), 64'd1);
        tick();
        rst = 1'b0;
        tick();

        // jal with fetch ready: immediate redirect.
        ex_valid = 1; jal_ex = 1; alu_tgt_ex = 32'h100; #1;
        chk("jal_sel", 64'(pc_sel), 64'd2);
        chk("jal_flush", 64'({if_id_flush, id_ex_flush, pc_we}), 64'b111);
        tick();
        idle_inputs();

        // jalr with busy fetch: latch, wait three cycles, then apply.
        ex_valid = 1; jalr_ex = 1; jalr_tgt_ex = 32'h2C; imem_ready = 0; #1;
        chk("jalr_busy_we", 64'(pc_we), 64'd0);
        tick();
        idle_inputs(); imem_ready = 0; #1;
        chk("wait_rpc", 64'(redirect_pc), 64'h2C);
        chk("wait_pending", 64'(redir_pending), 64'd1);
        chk("wait_we", 64'(pc_we), 64'd0);
        tick(); tick();
        imem_ready = 1; #1;
        chk("wait_apply_sel", 64'(pc_sel), 64'd3);
        tick(); #1;
        chk("back_run", 64'(redir_pending), 64'd0);
        chk("back_run_sel", 64'(pc_sel), 64'd0);

        // Load-use on rs2: exactly one bubble.
        ex_valid = 1; memrd_ex = 1; rd_ex = 5; rs2_id = 5; rs2_use_id = 1; #1;
        chk("lu_ctrl", 64'({pc_we, if_id_we, id_ex_flush}), 64'b001);
        tick();
        idle_inputs(); rs2_id = 5; rs2_use_id = 1; #1;
        chk("lu_one_cycle", 64'({pc_we, if_id_we, id_ex_flush}), 64'b110);
        ex_valid = 1; memrd_ex = 1; rd_ex = 0; rs2_id = 0; #1;
        chk("lu_x0", 64'({pc_we, if_id_we, id_ex_flush}), 64'b110);
        tick();

        // Branch plus load-use: redirect only.
        ex_valid = 1; memrd_ex = 1; br_ex = 1; rd_ex = 7; rs1_id = 7; rs1_use_id = 1;
        alu_tgt_ex = 32'h80; #1;
        chk("br_lu_sel", 64'(pc_sel), 64'd2);
        chk("br_lu_we", 64'({pc_we, if_id_we, if_id_flush}), 64'b111);
        tick();
        idle_inputs();

        // Data stall over a pending jal.
        rc0 = redirect_cnt; dc0 = dstall_cnt;
        ex_valid = 1; jal_ex = 1; alu_tgt_ex = 32'h40; dmem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("dstall_ctrl", 64'({pc_we, if_id_we, id_ex_we, pipe_hold, if_id_flush, id_ex_flush}),
                64'b000100);
            tick();
        end
        dmem_ready = 1; #1;
        chk("dstall_release_sel", 64'(pc_sel), 64'd2);
        tick();
        idle_inputs(); #1;
`ifdef PC_REDIRECT_PERF_EN
        chk("dstall_cnt4", 64'(dstall_cnt - dc0), 64'd4);
        chk("redirect_cnt1", 64'(redirect_cnt - rc0), 64'd1);
`endif

        // Reset while waiting drops the pending redirect.
        ex_valid = 1; jal_ex = 1; alu_tgt_ex = 32'h200; imem_ready = 0;
        tick();
        idle_inputs(); imem_ready = 0;
        rst = 1'b1; #1;
        chk("rst_wait_pending", 64'(redir_pending), 64'd0);
        chk("rst_wait_rpc", 64'(redirect_pc), 64'd0);
        tick();
        rst = 1'b0; imem_ready = 1; #1;
        chk("rst_wait_sel", 64'(pc_sel), 64'd0);
        tick();

        // Randomized traffic; EX carries no control transfer while a redirect is pending.
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 299) == 0);
            ex_valid    = ($urandom_range(0, 3) != 0);
            memrd_ex    = $urandom_range(0, 1);
            jal_ex      = ($urandom_range(0, 7) == 0);
            jalr_ex     = ($urandom_range(0, 7) == 0);
            br_ex       = ($urandom_range(0, 5) == 0);
            if (m_pend && !rst) begin
                jal_ex = 0; jalr_ex = 0; br_ex = 0;
            end
            jalr_tgt_ex = $urandom;
            alu_tgt_ex  = $urandom;
            rd_ex       = 5'($urandom_range(0, 4));
            rs1_id      = 5'($urandom_range(0, 4));
            rs2_id      = 5'($urandom_range(0, 4));
            rs1_use_id  = $urandom_range(0, 1);
            rs2_use_id  = $urandom_range(0, 1);
            imem_ready  = ($urandom_range(0, 9) < 6);
            dmem_ready  = ($urandom_range(0, 9) != 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
